// File: rtl/store_drain_arbiter_pkg.sv
// Shared types for the store drain path: memory access size, drain FSM
// states and the buffered store entry.
package store_drain_arbiter_pkg;

  localparam int DRAIN_XLEN  = 32;
  localparam int DRAIN_N_SQ  = 8;
  localparam int DRAIN_POS_W = $clog2(DRAIN_N_SQ) + 1;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    ISSUE
  } drain_state_e;

  typedef struct packed {
    logic [DRAIN_XLEN-1:0]  addr;
    logic [DRAIN_XLEN-1:0]  data;
    mem_size_e              size;
    logic [DRAIN_POS_W-1:0] pos;
  } drain_entry_t;

  // True when two addresses fall in the same 32-bit word; the low two bits
  // are masked by shifting the xor so every bit of both operands is consumed.
  function automatic logic same_word(input logic [DRAIN_XLEN-1:0] a,
                                     input logic [DRAIN_XLEN-1:0] b);
    return ((a ^ b) >> 2) == '0;
  endfunction

endpackage

// File: rtl/store_drain_arbiter_fifo.sv
// N_WAY-push / 1-pop circular buffer of retired stores. Valid push lanes are
// compacted in lane order at the tail; the head is exposed for issue and all
// addresses plus per-slot occupancy are exposed for the load hazard compare.
module store_drain_fifo
  import store_drain_arbiter_pkg::*;
#(
  parameter int N_WAY = 2,
  parameter int DEPTH = 4,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [N_WAY-1:0]                     push_valid,
  input  drain_entry_t [N_WAY-1:0]             push_entry,
  input  logic                                 pop,
  output drain_entry_t                         head_entry,
  output logic [CNT_W-1:0]                     count,
  output logic [DEPTH-1:0][DRAIN_XLEN-1:0]     entry_addr,
  output logic [DEPTH-1:0]                     entry_valid
);

  drain_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [IDX_W-1:0]         head_q, head_d;
  logic [IDX_W-1:0]         tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  int                       n_push;
  int                       slot;

  // Compact valid lanes into the tail, advance head on pop, update occupancy.
  always_comb begin
    mem_d  = mem_q;
    n_push = 0;
    slot   = 0;
    for (int i = 0; i < N_WAY; i++) begin
      if (push_valid[i]) begin
        slot = (int'(tail_q) + n_push) % DEPTH;
        mem_d[IDX_W'(slot)] = push_entry[i];
        n_push = n_push + 1;
      end
    end
    tail_d  = IDX_W'((int'(tail_q) + n_push) % DEPTH);
    head_d  = pop ? IDX_W'((int'(head_q) + 1) % DEPTH) : head_q;
    count_d = CNT_W'(int'(count_q) + n_push - (pop ? 1 : 0));
  end

  // Storage, pointers and count; the buffer contents are cleared on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Mark which physical slots hold live entries, measured from the head.
  always_comb begin
    entry_valid = '0;
    entry_addr  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entry_addr[k]  = mem_q[k].addr;
      entry_valid[k] = ((k - int'(head_q) + DEPTH) % DEPTH) < int'(count_q);
    end
  end

  assign head_entry = mem_q[head_q];
  assign count      = count_q;

endmodule

// File: rtl/store_drain_arbiter.sv
// Drains retired stores one per cycle into the single dcache write port,
// sharing that port with load-miss requests. Loads win by default unless the
// buffer is near full, a store has starved too long, or the load hits a
// buffered store's word. Each completed write is acknowledged to the store
// queue one cycle after its handshake.
module store_drain_arbiter
  import store_drain_arbiter_pkg::*;
#(
  parameter int N_WAY      = 2,
  parameter int N_SQ       = DRAIN_N_SQ,
  parameter int DEPTH      = 4,
  parameter int XLEN       = DRAIN_XLEN,
  parameter int STARVE_MAX = 4,
  localparam int POS_W     = $clog2(N_SQ) + 1,
  localparam int CNT_W     = $clog2(DEPTH) + 1,
  localparam int STV_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_WAY-1:0]        ret_valid,
  input  logic [N_WAY*XLEN-1:0]   ret_addr,
  input  logic [N_WAY*XLEN-1:0]   ret_data,
  input  logic [N_WAY*2-1:0]      ret_size,
  input  logic [N_WAY*POS_W-1:0]  ret_pos,
  output logic                    ret_ready,
  input  logic                    ld_req_valid,
  input  logic [XLEN-1:0]         ld_req_addr,
  output logic                    ld_grant,
  output logic                    dc_wr_valid,
  output logic [XLEN-1:0]         dc_wr_addr,
  output logic [XLEN-1:0]         dc_wr_data,
  output logic [1:0]              dc_wr_size,
  input  logic                    dc_wr_ready,
  output logic                    dc_ack_valid,
  output logic [XLEN-1:0]         dc_ack_addr,
  output logic [POS_W-1:0]        dc_ack_pos,
  output logic                    drain_empty,
  output logic                    err_overflow
);

  drain_state_e               state_q, state_d;
  logic [STV_W-1:0]           starve_q, starve_d;
  logic                       ack_valid_q, ack_valid_d;
  logic [XLEN-1:0]            ack_addr_q, ack_addr_d;
  logic [POS_W-1:0]           ack_pos_q, ack_pos_d;
  logic                       err_overflow_q, err_overflow_d;

  logic [N_WAY-1:0]           push_valid;
  drain_entry_t [N_WAY-1:0]   push_entry;
  int                         push_cnt;
  logic                       pop;
  drain_entry_t               head_entry;
  logic [CNT_W-1:0]           fifo_count;
  logic [DEPTH-1:0][DRAIN_XLEN-1:0] entry_addr;
  logic [DEPTH-1:0]           entry_valid;
  logic                       raw_hazard;

  assign ret_ready  = (DEPTH - int'(fifo_count)) >= N_WAY;
  assign push_valid = ret_valid & {N_WAY{ret_ready}};

  // Unpack the flat retirement lanes into entries and count accepted pushes.
  always_comb begin
    push_entry = '0;
    push_cnt   = 0;
    for (int i = 0; i < N_WAY; i++) begin
      push_entry[i].addr = ret_addr[i*XLEN +: XLEN];
      push_entry[i].data = ret_data[i*XLEN +: XLEN];
      push_entry[i].size = mem_size_e'(ret_size[i*2 +: 2]);
      push_entry[i].pos  = ret_pos[i*POS_W +: POS_W];
      if (push_valid[i]) push_cnt = push_cnt + 1;
    end
  end

  store_drain_fifo #(
    .N_WAY (N_WAY),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_entry  (push_entry),
    .pop         (pop),
    .head_entry  (head_entry),
    .count       (fifo_count),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  // A load that touches any buffered store's word must wait behind it.
  always_comb begin
    raw_hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_valid[k] && same_word(entry_addr[k], ld_req_addr)) raw_hazard = 1'b1;
    end
  end

  // Port arbitration FSM: grant loads, pick a store, hold the write until accepted.
  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    ld_grant       = 1'b0;
    dc_wr_valid    = 1'b0;
    pop            = 1'b0;
    ack_valid_d    = 1'b0;
    ack_addr_d     = ack_addr_q;
    ack_pos_d      = ack_pos_q;
    err_overflow_d = err_overflow_q | ((|ret_valid) & ~ret_ready);
    case (state_q)
      IDLE: begin
        ld_grant = ld_req_valid;
        if (push_cnt != 0) state_d = ARB;
      end
      ARB: begin
        if (!ld_req_valid || starve_q == STV_W'(STARVE_MAX) ||
            int'(fifo_count) >= DEPTH - 1 || raw_hazard) begin
          state_d  = ISSUE;
          starve_d = '0;
        end else begin
          ld_grant = 1'b1;
          if (starve_q != STV_W'(STARVE_MAX)) starve_d = starve_q + STV_W'(1);
        end
      end
      ISSUE: begin
        dc_wr_valid = 1'b1;
        if (dc_wr_ready) begin
          pop         = 1'b1;
          ack_valid_d = 1'b1;
          ack_addr_d  = head_entry.addr;
          ack_pos_d   = head_entry.pos;
          state_d     = (int'(fifo_count) + push_cnt > 1) ? ARB : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, starvation counter, completion pulse and sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      starve_q       <= '0;
      ack_valid_q    <= 1'b0;
      ack_addr_q     <= '0;
      ack_pos_q      <= '0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      ack_valid_q    <= ack_valid_d;
      ack_addr_q     <= ack_addr_d;
      ack_pos_q      <= ack_pos_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign dc_wr_addr   = head_entry.addr;
  assign dc_wr_data   = head_entry.data;
  assign dc_wr_size   = head_entry.size;
  assign dc_ack_valid = ack_valid_q;
  assign dc_ack_addr  = ack_addr_q;
  assign dc_ack_pos   = ack_pos_q;
  assign drain_empty  = (fifo_count == '0) && !dc_wr_valid;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_store_drain_arbiter.sv
// Scenario bench for store_drain_arbiter. Expected writes and completions are
// queued as stores are pushed and checked in order by monitors.
module tb_store_drain_arbiter;
  import store_drain_arbiter_pkg::*;

  localparam int N_WAY = 2;
  localparam int N_SQ = 8;
  localparam int DEPTH = 4;
  localparam int XLEN = 32;
  localparam int STARVE_MAX = 4;
  localparam int POS_W = 4;

  logic                   clock;
  logic                   reset;
  logic [N_WAY-1:0]       ret_valid;
  logic [N_WAY*XLEN-1:0]  ret_addr;
  logic [N_WAY*XLEN-1:0]  ret_data;
  logic [N_WAY*2-1:0]     ret_size;
  logic [N_WAY*POS_W-1:0] ret_pos;
  logic                   ret_ready;
  logic                   ld_req_valid;
  logic [XLEN-1:0]        ld_req_addr;
  logic                   ld_grant;
  logic                   dc_wr_valid;
  logic [XLEN-1:0]        dc_wr_addr;
  logic [XLEN-1:0]        dc_wr_data;
  logic [1:0]             dc_wr_size;
  logic                   dc_wr_ready;
  logic                   dc_ack_valid;
  logic [XLEN-1:0]        dc_ack_addr;
  logic [POS_W-1:0]       dc_ack_pos;
  logic                   drain_empty;
  logic                   err_overflow;

  store_drain_arbiter #(
    .N_WAY(N_WAY), .N_SQ(N_SQ), .DEPTH(DEPTH), .XLEN(XLEN), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .ret_valid(ret_valid), .ret_addr(ret_addr), .ret_data(ret_data),
    .ret_size(ret_size), .ret_pos(ret_pos), .ret_ready(ret_ready),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_grant(ld_grant),
    .dc_wr_valid(dc_wr_valid), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
    .dc_wr_size(dc_wr_size), .dc_wr_ready(dc_wr_ready),
    .dc_ack_valid(dc_ack_valid), .dc_ack_addr(dc_ack_addr), .dc_ack_pos(dc_ack_pos),
    .drain_empty(drain_empty), .err_overflow(err_overflow)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [3:0]  pos;
  } exp_t;

  exp_t wr_q[$];
  exp_t ack_q[$];
  exp_t we, ae;
  int tests_run = 0;
  int tests_failed = 0;
  bit done;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Write-port and completion scoreboards, sampled mid-cycle.
  always @(negedge clock) begin
    #3;
    if (!reset) begin
      if (dc_wr_valid && dc_wr_ready) begin
        tests_run++;
        if (wr_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL wr_unexpected: got addr %0h expected none", dc_wr_addr);
        end else begin
          we = wr_q.pop_front();
          if ({dc_wr_addr, dc_wr_data, dc_wr_size} !== {we.addr, we.data, we.size}) begin
            tests_failed++;
            $display("[TB] FAIL wr_payload: got %0h/%0h/%0d expected %0h/%0h/%0d",
                     dc_wr_addr, dc_wr_data, dc_wr_size, we.addr, we.data, we.size);
          end
        end
      end
      if (dc_ack_valid) begin
        tests_run++;
        if (ack_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL ack_unexpected: got pos %0d expected none", dc_ack_pos);
        end else begin
          ae = ack_q.pop_front();
          if ({dc_ack_addr, dc_ack_pos} !== {ae.addr, ae.pos}) begin
            tests_failed++;
            $display("[TB] FAIL ack_order: got %0h/pos %0d expected %0h/pos %0d",
                     dc_ack_addr, dc_ack_pos, ae.addr, ae.pos);
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    ret_valid = '0; ret_addr = '0; ret_data = '0; ret_size = '0; ret_pos = '0;
    ld_req_valid = 1'b0; ld_req_addr = '0;
  endtask

  task automatic set_lane(input logic lane, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic [3:0] pos, input bit accept);
    exp_t e;
    ret_valid[lane] = 1'b1;
    ret_addr[int'(lane)*XLEN +: XLEN] = addr;
    ret_data[int'(lane)*XLEN +: XLEN] = data;
    ret_size[int'(lane)*2 +: 2] = size;
    ret_pos[int'(lane)*POS_W +: POS_W] = pos;
    if (accept) begin
      e.addr = addr; e.data = data; e.size = size; e.pos = pos;
      wr_q.push_back(e);
      ack_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    dc_wr_ready = 1'b0;
    wr_q.delete();
    ack_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      #4;
      if (drain_empty && wr_q.size() == 0 && ack_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    dc_wr_ready = 1'b0;
    #1;
    tests_run++;
    if ({ret_ready, drain_empty, dc_wr_valid, dc_ack_valid, err_overflow, ld_grant} !== 6'b110000) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected 110000",
               {ret_ready, drain_empty, dc_wr_valid, dc_ack_valid, err_overflow, ld_grant});
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({dc_wr_addr, dc_ack_addr, dc_ack_pos} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_payload: got %0h/%0h/%0d expected 0/0/0", dc_wr_addr, dc_ack_addr, dc_ack_pos);
    end
    @(negedge clock);
    ld_req_valid = 1'b1; ld_req_addr = 32'h40;
    #1;
    tests_run++;
    if (ld_grant !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL idle_load_grant: got %b expected 1", ld_grant);
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_single_store();
    dc_wr_ready = 1'b1;
    @(negedge clock); idle_inputs(); set_lane(1'b0, 32'h100, 32'hDEADBEEF, WORD, 4'd3, 1'b1); #1;
    tests_run++;
    if (ret_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL single_ready: got %b expected 1", ret_ready);
    end
    @(negedge clock); idle_inputs(); #1;
    tests_run++;
    if (dc_wr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL single_t1_wr: got %b expected 0", dc_wr_valid);
    end
    @(negedge clock); #1;
    tests_run++;
    if ({dc_wr_valid, dc_wr_addr} !== {1'b1, 32'h100}) begin
      tests_failed++; $display("[TB] FAIL single_t2_wr: got %b/%0h expected 1/100", dc_wr_valid, dc_wr_addr);
    end
    @(negedge clock); #1;
    tests_run++;
    if ({dc_ack_valid, dc_ack_pos, drain_empty} !== {1'b1, 4'd3, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL single_t3_ack: got %b/%0d/%b expected 1/3/1", dc_ack_valid, dc_ack_pos, drain_empty);
    end
    @(negedge clock); #1;
    tests_run++;
    if (dc_ack_valid !== 1'b0 || ack_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL single_ack_pulse: got %b/%0d left expected 0/0", dc_ack_valid, ack_q.size());
    end
  endtask

  task automatic test_dual_backpressure();
    dc_wr_ready = 1'b0;
    @(negedge clock); idle_inputs();
    set_lane(1'b0, 32'h110, 32'h11111111, WORD, 4'd1, 1'b1);
    set_lane(1'b1, 32'h120, 32'h22220000, HALF, 4'd2, 1'b1);
    @(negedge clock); idle_inputs();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      ld_req_valid = 1'b1; ld_req_addr = 32'h800;
      #1;
      tests_run++;
      if ({dc_wr_valid, dc_wr_addr, dc_wr_data, ld_grant} !== {1'b1, 32'h110, 32'h11111111, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL dual_hold: got %b/%0h/%0h/grant %b expected 1/110/11111111/grant 0",
                 dc_wr_valid, dc_wr_addr, dc_wr_data, ld_grant);
      end
    end
    @(negedge clock); idle_inputs(); dc_wr_ready = 1'b1;
    wait_drain(done);
    tests_run++;
    if (!done) begin
      tests_failed++; $display("[TB] FAIL dual_drain: got %0d acks pending expected 0", ack_q.size());
    end
  endtask

  task automatic test_starvation();
    dc_wr_ready = 1'b1;
    @(negedge clock); idle_inputs(); set_lane(1'b0, 32'h300, 32'h33333333, WORD, 4'd4, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock); idle_inputs(); ld_req_valid = 1'b1; ld_req_addr = 32'h400; #1;
      tests_run++;
      if ({ld_grant, dc_wr_valid} !== 2'b10) begin
        tests_failed++; $display("[TB] FAIL starve_grant_%0d: got %b expected 10", c, {ld_grant, dc_wr_valid});
      end
    end
    @(negedge clock); #1;
    tests_run++;
    if ({ld_grant, dc_wr_valid} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL starve_force: got %b expected 00", {ld_grant, dc_wr_valid});
    end
    @(negedge clock); #1;
    tests_run++;
    if ({ld_grant, dc_wr_valid, dc_wr_addr} !== {2'b01, 32'h300}) begin
      tests_failed++; $display("[TB] FAIL starve_issue: got %b/%0h expected 01/300", {ld_grant, dc_wr_valid}, dc_wr_addr);
    end
    @(negedge clock); #1;
    tests_run++;
    if (ld_grant !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL starve_after: got %b expected 1", ld_grant);
    end
    @(negedge clock); idle_inputs();
    wait_drain(done);
    tests_run++;
    if (!done) begin
      tests_failed++; $display("[TB] FAIL starve_drain: got %0d acks pending expected 0", ack_q.size());
    end
  endtask

  task automatic test_high_water();
    dc_wr_ready = 1'b1;
    @(negedge clock); idle_inputs();
    set_lane(1'b0, 32'h1A0, 32'hA0, WORD, 4'd5, 1'b1);
    set_lane(1'b1, 32'h1A4, 32'hA4, WORD, 4'd6, 1'b1);
    @(negedge clock); idle_inputs();
    set_lane(1'b0, 32'h1A8, 32'hA8, BYTE, 4'd7, 1'b1);
    ld_req_valid = 1'b1; ld_req_addr = 32'h900; #1;
    tests_run++;
    if (ld_grant !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL hw_below: got %b expected 1", ld_grant);
    end
    @(negedge clock); idle_inputs(); ld_req_valid = 1'b1; ld_req_addr = 32'h900; #1;
    tests_run++;
    if (ld_grant !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL hw_at_mark: got %b expected 0", ld_grant);
    end
    @(negedge clock); idle_inputs();
    wait_drain(done);
    tests_run++;
    if (!done) begin
      tests_failed++; $display("[TB] FAIL hw_drain: got %0d acks pending expected 0", ack_q.size());
    end
  endtask

  task automatic test_raw_hazard();
    dc_wr_ready = 1'b1;
    @(negedge clock); idle_inputs(); set_lane(1'b0, 32'h200, 32'h20202020, WORD, 4'd5, 1'b1);
    @(negedge clock); idle_inputs(); ld_req_valid = 1'b1; ld_req_addr = 32'h202; #1;
    tests_run++;
    if ({ld_grant, dc_wr_valid} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL raw_block: got %b expected 00", {ld_grant, dc_wr_valid});
    end
    @(negedge clock); #1;
    tests_run++;
    if ({ld_grant, dc_wr_valid} !== 2'b01) begin
      tests_failed++; $display("[TB] FAIL raw_issue: got %b expected 01", {ld_grant, dc_wr_valid});
    end
    @(negedge clock); #1;
    tests_run++;
    if (ld_grant !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL raw_release: got %b expected 1", ld_grant);
    end
    @(negedge clock); idle_inputs();
    wait_drain(done);
    tests_run++;
    if (!done) begin
      tests_failed++; $display("[TB] FAIL raw_drain: got %0d acks pending expected 0", ack_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock); idle_inputs();
      dc_wr_ready = 1'($urandom_range(0, 1));
      if (ret_ready) begin
        if (c % 3 != 1) begin
          set_lane(1'b0, 32'h1000 + 32'(n * 4), 32'hC000 + 32'(n), WORD, 4'(n % 8 + 1), 1'b1);
          n++;
        end
        if (c % 3 != 0) begin
          set_lane(1'b1, 32'h1000 + 32'(n * 4), 32'hC000 + 32'(n), HALF, 4'(n % 8 + 1), 1'b1);
          n++;
        end
      end
    end
    @(negedge clock); idle_inputs(); dc_wr_ready = 1'b1;
    wait_drain(done);
    tests_run++;
    if (!done || err_overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_drain: got %0d pending/ovf %b expected 0/0", ack_q.size(), err_overflow);
    end
  endtask

  task automatic test_overflow();
    dc_wr_ready = 1'b0;
    @(negedge clock); idle_inputs();
    set_lane(1'b0, 32'h500, 32'h5, WORD, 4'd1, 1'b1);
    set_lane(1'b1, 32'h504, 32'h6, WORD, 4'd2, 1'b1);
    @(negedge clock); idle_inputs(); set_lane(1'b0, 32'h508, 32'h7, WORD, 4'd3, 1'b1); #1;
    tests_run++;
    if (ret_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL ovf_ready_cnt2: got %b expected 1", ret_ready);
    end
    @(negedge clock); idle_inputs(); set_lane(1'b0, 32'h50C, 32'h8, WORD, 4'd4, 1'b0); #1;
    tests_run++;
    if ({ret_ready, err_overflow} !== 2'b00) begin
      tests_failed++; $display("[TB] FAIL ovf_ready_cnt3: got %b expected 00", {ret_ready, err_overflow});
    end
    @(negedge clock); idle_inputs(); #1;
    tests_run++;
    if ({ret_ready, err_overflow} !== 2'b01) begin
      tests_failed++; $display("[TB] FAIL ovf_set_cnt3: got %b expected 01", {ret_ready, err_overflow});
    end
    dc_wr_ready = 1'b1;
    wait_drain(done);
    tests_run++;
    if (!done || err_overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ovf_drain3: got %0d pending/ovf %b expected 0/1", ack_q.size(), err_overflow);
    end
    do_reset();
    #1;
    tests_run++;
    if (err_overflow !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ovf_reset_clear: got %b expected 0", err_overflow);
    end
    @(negedge clock); idle_inputs();
    set_lane(1'b0, 32'h600, 32'h60, WORD, 4'd5, 1'b1);
    set_lane(1'b1, 32'h604, 32'h64, WORD, 4'd6, 1'b1);
    @(negedge clock); idle_inputs();
    set_lane(1'b0, 32'h608, 32'h68, WORD, 4'd7, 1'b1);
    set_lane(1'b1, 32'h60C, 32'h6C, WORD, 4'd8, 1'b1);
    @(negedge clock); idle_inputs();
    set_lane(1'b0, 32'h700, 32'h70, WORD, 4'd1, 1'b0);
    set_lane(1'b1, 32'h704, 32'h74, WORD, 4'd2, 1'b0);
    #1;
    tests_run++;
    if (ret_ready !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL ovf_ready_full: got %b expected 0", ret_ready);
    end
    @(negedge clock); idle_inputs(); #1;
    tests_run++;
    if (err_overflow !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL ovf_set_full: got %b expected 1", err_overflow);
    end
    dc_wr_ready = 1'b1;
    wait_drain(done);
    tests_run++;
    if (!done || ret_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ovf_drain4: got %0d pending/ready %b expected 0/1", ack_q.size(), ret_ready);
    end
  endtask

  task automatic test_reset_mid_issue();
    dc_wr_ready = 1'b0;
    @(negedge clock); idle_inputs(); set_lane(1'b0, 32'h900, 32'h99, WORD, 4'd2, 1'b1);
    @(negedge clock); idle_inputs();
    @(negedge clock); #1;
    tests_run++;
    if ({dc_wr_valid, err_overflow} !== 2'b11) begin
      tests_failed++; $display("[TB] FAIL rst_pre: got %b expected 11", {dc_wr_valid, err_overflow});
    end
    #1;
    reset = 1'b1;
    wr_q.delete();
    ack_q.delete();
    #1;
    tests_run++;
    if ({dc_wr_valid, ret_ready, err_overflow, drain_empty} !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL rst_async: got %b expected 0101", {dc_wr_valid, ret_ready, err_overflow, drain_empty});
    end
    @(negedge clock); reset = 1'b0; dc_wr_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    tests_run++;
    if ({dc_wr_valid, drain_empty} !== 2'b01) begin
      tests_failed++; $display("[TB] FAIL rst_after: got %b expected 01", {dc_wr_valid, drain_empty});
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_dual_backpressure();
    test_starvation();
    test_high_water();
    test_raw_hazard();
    test_back_to_back();
    test_overflow();
    test_reset_mid_issue();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/store_drain_arbiter.md
Name: store_drain_arbiter

Overview:
- Sits between the store queue's retirement output and the single data-cache port.
- Buffers retired stores (up to N_WAY per cycle) and drains them one per cycle into the dcache write channel.
- Arbitrates the same port against load-miss requests.
- Returns a per-store completion (address, store_pos) that the store queue uses to free the retired entry.

Parameters:
N_WAY, 2, retire/dispatch width; max stores pushed per cycle
N_SQ, 8, store queue entries; store_pos is 1-based, width $clog2(N_SQ)+1
DEPTH, 4, drain buffer entries; must be >= N_WAY
XLEN, 32, address/data width
STARVE_MAX, 4, cycles a ready store may lose to loads before it is forced through

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ret_valid  in  N_WAY  retired-store valid per lane; lane 0 is oldest
ret_addr  in  N_WAY*XLEN  store address per lane
ret_data  in  N_WAY*XLEN  store data per lane
ret_size  in  N_WAY*2  BYTE/HALF/WORD per lane
ret_pos  in  N_WAY*($clog2(N_SQ)+1)  store queue slot per lane
ret_ready  out  1  buffer can absorb N_WAY pushes this cycle
ld_req_valid  in  1  load miss wants the port
ld_req_addr  in  XLEN  load address
ld_grant  out  1  load owns the port this cycle
dc_wr_valid  out  1  store write presented
dc_wr_addr  out  XLEN  write address
dc_wr_data  out  XLEN  write data
dc_wr_size  out  2  write size
dc_wr_ready  in  1  dcache accepts write
dc_ack_valid  out  1  completion pulse to store queue
dc_ack_addr  out  XLEN  completed address
dc_ack_pos  out  $clog2(N_SQ)+1  completed store_pos
drain_empty  out  1  buffer empty and no write outstanding
err_overflow  out  1  sticky: push attempted while !ret_ready

Behaviour:
- Reset (asynchronous, active-high): buffer cleared, count=0, FSM=IDLE, starve=0. Outputs all 0 except ret_ready=1 and drain_empty=1.
- Push:
  - Valid lanes are compacted in lane order into the FIFO tail; count increases by popcount(ret_valid).
  - ret_ready = (DEPTH-count) >= N_WAY, combinational from the registered count.
  - ret_valid while !ret_ready: entries dropped, err_overflow set until reset.
- FSM states:
  - IDLE: count==0. Any load is granted (ld_grant=ld_req_valid). A push at t moves to ARB at t+1.
  - ARB: head entry eligible; dc_wr_valid=0. Store wins if any of:
    - no ld_req_valid;
    - starve==STARVE_MAX;
    - count>=DEPTH-1 (high-water);
    - ld_req_addr[XLEN-1:2] equals any buffered entry's addr[XLEN-1:2] (RAW hazard; load must wait).
  - ARB outcomes:
    - Store wins: go to ISSUE next cycle, starve=0.
    - Load wins: ld_grant=1, starve+1 (saturating), stay in ARB.
  - ISSUE:
    - dc_wr_valid=1 with head payload, held stable until dc_wr_ready. ld_grant=0 throughout.
    - On handshake: pop head; next cycle dc_ack_valid=1 with that addr/pos for exactly one cycle.
    - Next state: ARB if remaining count>0 (including same-cycle pushes), else IDLE.
- Minimum latency: push at t, dc_wr_valid at t+2, ack at t+3 when dc_wr_ready=1 at t+2.
- Simultaneous push and pop in one cycle are legal; count = count + pushes - 1.
- Stores drain in strict FIFO order; no reordering or merging.
- Not flushed by branch hazards (retired stores are architectural).
- drain_empty = (count==0) && !dc_wr_valid.
- Pointer wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits and never exceeds DEPTH.

Decomposition:
- Shared package: DRAIN_ENTRY struct {addr, data, size, pos}, reuse of the existing MEM_SIZE enum (BYTE/HALF/WORD), and the DRAIN_STATE enum {IDLE, ARB, ISSUE}.
- Sub-module store_drain_fifo: N_WAY-push/1-pop circular buffer with count output and a flat entries output for the hazard compare. The arbiter FSM and starve counter stay in the top module.

Test Plan:
- Single store: push lane0 addr 0x100 data 0xDEADBEEF WORD pos 3 at t, dc_wr_ready=1 -> dc_wr_valid at t+2 with addr 0x100; dc_ack_valid at t+3 with pos 3; drain_empty=1 at t+3.
- Dual push then backpressure: both lanes valid (pos 1, 2), dc_wr_ready=0 for 5 cycles -> dc_wr_valid held with pos1 payload stable; after ready, acks in order pos1, pos2.
- Starvation: one store buffered, ld_req_valid=1 continuously, addr 0x400 -> ld_grant for exactly 4 ARB cycles, then the store issues.
- RAW hazard: buffered store 0x200; load at 0x202 -> ld_grant=0; store issues first; ld_grant=1 the cycle after the pop.
- Full/overflow: fill to DEPTH=4 with dc_wr_ready=0 -> ret_ready=0 at count 3; a push at count 4 sets err_overflow=1 and count stays 4.
- Async reset mid-ISSUE: assert reset between clock edges -> dc_wr_valid=0 immediately; count=0, ret_ready=1, err_overflow=0.
